// File: rtl/axi4_lite_slave_dual.sv
// AXI4-Lite slave bridging to a simple req/ack backend, with independent write and read FSMs.
// Define AXI_LITE_DECERR_EN to answer DECERR locally for addresses outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN).
module axi4_lite_slave_dual #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
  parameter longint unsigned         ADDR_SPAN  = 4096
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    s_AWVALID,
  input  logic [ADDR_WIDTH-1:0]   s_AWADDR,
  output logic                    s_AWREADY,
  input  logic                    s_WVALID,
  input  logic [DATA_WIDTH-1:0]   s_WDATA,
  input  logic [DATA_WIDTH/8-1:0] s_WSTRB,
  output logic                    s_WREADY,
  output logic                    s_BVALID,
  output logic [1:0]              s_BRESP,
  input  logic                    s_BREADY,
  input  logic                    s_ARVALID,
  input  logic [ADDR_WIDTH-1:0]   s_ARADDR,
  output logic                    s_ARREADY,
  output logic                    s_RVALID,
  output logic [DATA_WIDTH-1:0]   s_RDATA,
  output logic [1:0]              s_RRESP,
  input  logic                    s_RREADY,
  output logic                    wr_req,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_ack,
  input  logic                    wr_err,
  output logic                    rd_req,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_ack,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_err
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_BACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_BACK, R_DATA} r_state_t;

  w_state_t                w_state, w_state_n;
  logic                    aw_full, aw_full_n, w_full, w_full_n;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_n;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_n;
  logic [STRB_WIDTH-1:0]   w_strb_q, w_strb_n;
  logic                    awready_q, awready_n, wready_q, wready_n;
  logic                    wr_req_q, wr_req_n, bvalid_q, bvalid_n;
  logic [1:0]              bresp_q, bresp_n;

  r_state_t                r_state, r_state_n;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_n;
  logic                    arready_q, arready_n, rd_req_q, rd_req_n, rvalid_q, rvalid_n;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_n;
  logic [1:0]              rresp_q, rresp_n;

  logic                    aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0]   aw_addr_sel;
  logic                    aw_in_win, ar_in_win;

  assign aw_hs       = s_AWVALID & awready_q;
  assign w_hs        = s_WVALID  & wready_q;
  assign ar_hs       = s_ARVALID & arready_q;
  assign aw_addr_sel = aw_hs ? s_AWADDR : aw_addr_q;

`ifdef AXI_LITE_DECERR_EN
  // One extra bit so a window touching the top of the address space does not wrap.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(ADDR_SPAN);
  assign aw_in_win = ({1'b0, aw_addr_sel} >= WIN_LO) && ({1'b0, aw_addr_sel} < WIN_HI);
  assign ar_in_win = ({1'b0, s_ARADDR} >= WIN_LO) && ({1'b0, s_ARADDR} < WIN_HI);
`else
  assign aw_in_win = 1'b1;
  assign ar_in_win = 1'b1;
`endif

  always_comb begin
    w_state_n = w_state;
    aw_full_n = aw_full;
    w_full_n  = w_full;
    aw_addr_n = aw_addr_q;
    w_data_n  = w_data_q;
    w_strb_n  = w_strb_q;
    awready_n = awready_q;
    wready_n  = wready_q;
    wr_req_n  = wr_req_q;
    bvalid_n  = bvalid_q;
    bresp_n   = bresp_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_full_n = 1'b1;
          aw_addr_n = s_AWADDR;
        end
        if (w_hs) begin
          w_full_n = 1'b1;
          w_data_n = s_WDATA;
          w_strb_n = s_WSTRB;
        end
        awready_n = ~aw_full_n;
        wready_n  = ~w_full_n;
        if (aw_full_n && w_full_n) begin
          if (aw_in_win) begin
            wr_req_n  = 1'b1;
            w_state_n = W_BACK;
          end else begin
            bvalid_n  = 1'b1;
            bresp_n   = RESP_DECERR;
            w_state_n = W_RESP;
          end
        end
      end
      W_BACK: begin
        if (wr_ack) begin
          wr_req_n  = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = wr_err ? RESP_SLVERR : RESP_OKAY;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        if (s_BREADY) begin
          bvalid_n  = 1'b0;
          bresp_n   = RESP_OKAY;
          aw_full_n = 1'b0;
          w_full_n  = 1'b0;
          aw_addr_n = '0;
          w_data_n  = '0;
          w_strb_n  = '0;
          awready_n = 1'b1;
          wready_n  = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_n = r_state;
    rd_addr_n = rd_addr_q;
    arready_n = arready_q;
    rd_req_n  = rd_req_q;
    rvalid_n  = rvalid_q;
    rdata_n   = rdata_q;
    rresp_n   = rresp_q;
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (ar_hs) begin
          arready_n = 1'b0;
          rd_addr_n = s_ARADDR;
          if (ar_in_win) begin
            rd_req_n  = 1'b1;
            r_state_n = R_BACK;
          end else begin
            rvalid_n  = 1'b1;
            rdata_n   = '0;
            rresp_n   = RESP_DECERR;
            r_state_n = R_DATA;
          end
        end
      end
      R_BACK: begin
        if (rd_ack) begin
          rd_req_n  = 1'b0;
          rvalid_n  = 1'b1;
          rdata_n   = rd_data;
          rresp_n   = rd_err ? RESP_SLVERR : RESP_OKAY;
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (s_RREADY) begin
          rvalid_n  = 1'b0;
          rdata_n   = '0;
          rresp_n   = RESP_OKAY;
          arready_n = 1'b1;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      w_state   <= W_IDLE;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      r_state   <= R_IDLE;
      rd_addr_q <= '0;
      arready_q <= 1'b0;
      rd_req_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state   <= w_state_n;
      aw_full   <= aw_full_n;
      w_full    <= w_full_n;
      aw_addr_q <= aw_addr_n;
      w_data_q  <= w_data_n;
      w_strb_q  <= w_strb_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      wr_req_q  <= wr_req_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
      r_state   <= r_state_n;
      rd_addr_q <= rd_addr_n;
      arready_q <= arready_n;
      rd_req_q  <= rd_req_n;
      rvalid_q  <= rvalid_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
    end
  end

  assign s_AWREADY = awready_q;
  assign s_WREADY  = wready_q;
  assign s_BVALID  = bvalid_q;
  assign s_BRESP   = bresp_q;
  assign wr_req    = wr_req_q;
  assign wr_addr   = aw_addr_q;
  assign wr_data   = w_data_q;
  assign wr_strb   = w_strb_q;
  assign s_ARREADY = arready_q;
  assign s_RVALID  = rvalid_q;
  assign s_RDATA   = rdata_q;
  assign s_RRESP   = rresp_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_axi4_lite_slave_dual.sv
// Scoreboard bench for axi4_lite_slave_dual: random AXI-Lite traffic against a word-memory model and a req/ack backend.
module tb_axi4_lite_slave_dual;
  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        s_AWVALID, s_AWREADY, s_WVALID, s_WREADY, s_BVALID, s_BREADY;
  logic [31:0] s_AWADDR, s_WDATA, s_ARADDR, s_RDATA;
  logic [3:0]  s_WSTRB;
  logic [1:0]  s_BRESP, s_RRESP;
  logic        s_ARVALID, s_ARREADY, s_RVALID, s_RREADY;
  logic        wr_req, wr_ack, wr_err, rd_req, rd_ack, rd_err;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]  wr_strb;
  logic        any_out;

  always #5 iCLK = ~iCLK;

  axi4_lite_slave_dual #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .ADDR_SPAN(4096)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .s_AWVALID(s_AWVALID), .s_AWADDR(s_AWADDR), .s_AWREADY(s_AWREADY),
    .s_WVALID(s_WVALID), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WREADY(s_WREADY),
    .s_BVALID(s_BVALID), .s_BRESP(s_BRESP), .s_BREADY(s_BREADY),
    .s_ARVALID(s_ARVALID), .s_ARADDR(s_ARADDR), .s_ARREADY(s_ARREADY),
    .s_RVALID(s_RVALID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RREADY(s_RREADY),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err)
  );

  assign any_out = |{s_AWREADY, s_WREADY, s_BVALID, s_BRESP, s_ARREADY, s_RVALID, s_RDATA, s_RRESP,
                     wr_req, wr_addr, wr_data, wr_strb, rd_req, rd_addr};

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; bit err; int lat; } be_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;

  be_t         wr_be_q[$], rd_be_q[$];
  logic [1:0]  b_exp_q[$];
  rexp_t       r_exp_q[$];
  logic [31:0] mem  [int unsigned];
  logic [31:0] bmem [int unsigned];
  int          n_checks = 0, n_fail = 0;
  int          wr_lat_force = -1, rd_lat_force = -1, rready_block = 0;
  bit          saw_both = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred, required none at %0t", name, $time);
  endtask

  function automatic bit in_win(input logic [31:0] a);
`ifdef AXI_LITE_DECERR_EN
    return a < 32'h1000;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit be_err(input logic [31:0] a);
    return a >= 32'h800;
  endfunction

  function automatic logic [31:0] err_word(input logic [31:0] a);
    return 32'hBAD0_0000 ^ a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (mem.exists(a >> 2)) return mem[a >> 2];
    return '0;
  endfunction

  function automatic logic [31:0] back_rd(input logic [31:0] a);
    if (bmem.exists(a >> 2)) return bmem[a >> 2];
    return '0;
  endfunction

  // Backend write side: checks presented request, acks after a per-transaction latency.
  be_t cur_w, cur_r;
  bit  wr_busy = 0, rd_busy = 0;
  int  wr_cnt = 0, rd_cnt = 0;
  always @(negedge iCLK) begin
    if (!iRST) begin
      wr_busy = 0; wr_ack = 0; wr_err = 0;
    end else begin
      wr_ack = 0; wr_err = 0;
      if (wr_req && !wr_busy) begin
        if (wr_be_q.size() == 0) fail("unexpected_wr_req");
        else begin
          cur_w = wr_be_q.pop_front();
          check("wr_addr", wr_addr, cur_w.addr);
          check("wr_data", wr_data, cur_w.data);
          check("wr_strb", wr_strb, cur_w.strb);
          wr_cnt  = cur_w.lat;
          wr_busy = 1;
        end
      end
      if (wr_busy) begin
        if (wr_cnt == 0) begin
          wr_ack = 1; wr_err = cur_w.err; wr_busy = 0;
          if (!cur_w.err) bmem[wr_addr >> 2] = merge(back_rd(wr_addr), wr_data, wr_strb);
        end else wr_cnt--;
      end else if (!wr_req && $urandom_range(0, 7) == 0) begin
        wr_ack = 1; wr_err = 1;
      end
    end
  end

  always @(negedge iCLK) begin
    if (!iRST) begin
      rd_busy = 0; rd_ack = 0; rd_err = 0; rd_data = '0;
    end else begin
      rd_ack = 0; rd_err = 0; rd_data = '0;
      if (rd_req && !rd_busy) begin
        if (rd_be_q.size() == 0) fail("unexpected_rd_req");
        else begin
          cur_r = rd_be_q.pop_front();
          check("rd_addr", rd_addr, cur_r.addr);
          rd_cnt  = cur_r.lat;
          rd_busy = 1;
        end
      end
      if (rd_busy) begin
        if (rd_cnt == 0) begin
          rd_ack = 1; rd_err = cur_r.err; rd_busy = 0;
          rd_data = cur_r.err ? err_word(cur_r.addr) : back_rd(cur_r.addr);
        end else rd_cnt--;
      end else if (!rd_req && $urandom_range(0, 7) == 0) begin
        rd_ack = 1; rd_err = 1; rd_data = $urandom;
      end
    end
  end

  // Response monitor: drives B/R ready for the coming edge, then scores what that edge will accept.
  bit         bstall = 0, rstall = 0;
  logic [1:0] prev_bresp, prev_rresp;
  logic [31:0] prev_rdata;
  rexp_t      rx;
  always @(negedge iCLK) begin
    if (!iRST) begin
      s_BREADY = 0; s_RREADY = 0; bstall = 0; rstall = 0;
    end else begin
      s_BREADY = ($urandom_range(0, 3) != 0);
      if (s_RVALID && rready_block > 0) begin
        s_RREADY = 0; rready_block--;
      end else s_RREADY = ($urandom_range(0, 3) != 0);
      if (wr_req && rd_req) saw_both = 1;

      if (bstall) begin
        check("b_held_valid", s_BVALID, 1'b1);
        check("b_held_resp", s_BRESP, prev_bresp);
      end
      if (s_BVALID) begin
        if (s_BREADY) begin
          if (b_exp_q.size() == 0) fail("unexpected_b");
          else check("bresp", s_BRESP, b_exp_q.pop_front());
          bstall = 0;
        end else begin
          bstall = 1; prev_bresp = s_BRESP;
        end
      end else begin
        bstall = 0;
        check("bresp_idle", s_BRESP, 2'b00);
      end

      if (rstall) begin
        check("r_held_valid", s_RVALID, 1'b1);
        check("r_held_data", s_RDATA, prev_rdata);
        check("r_held_resp", s_RRESP, prev_rresp);
      end
      if (s_RVALID) begin
        if (s_RREADY) begin
          if (r_exp_q.size() == 0) fail("unexpected_r");
          else begin
            rx = r_exp_q.pop_front();
            check("rdata", s_RDATA, rx.data);
            check("rresp", s_RRESP, rx.resp);
          end
          rstall = 0;
        end else begin
          rstall = 1; prev_rdata = s_RDATA; prev_rresp = s_RRESP;
        end
      end else begin
        rstall = 0;
        check("rdata_idle", {s_RDATA, s_RRESP}, 34'h0);
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    s_AWVALID = 1; s_AWADDR = a;
    while (!s_AWREADY && n < 50) begin @(negedge iCLK); n++; end
    if (n >= 50) fail("aw_ready_timeout");
    @(negedge iCLK);
    s_AWVALID = 0; s_AWADDR = '0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_WVALID = 1; s_WDATA = d; s_WSTRB = s;
    while (!s_WREADY && n < 50) begin @(negedge iCLK); n++; end
    if (n >= 50) fail("w_ready_timeout");
    @(negedge iCLK);
    s_WVALID = 0; s_WDATA = '0; s_WSTRB = '0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    s_ARVALID = 1; s_ARADDR = a;
    while (!s_ARREADY && n < 50) begin @(negedge iCLK); n++; end
    if (n >= 50) fail("ar_ready_timeout");
    @(negedge iCLK);
    s_ARVALID = 0; s_ARADDR = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int daw, input int dw);
    be_t e;
    if (!in_win(a)) b_exp_q.push_back(2'b11);
    else begin
      e.addr = a; e.data = d; e.strb = s; e.err = be_err(a);
      e.lat  = (wr_lat_force >= 0) ? wr_lat_force : int'($urandom_range(0, 4));
      wr_be_q.push_back(e);
      b_exp_q.push_back(e.err ? 2'b10 : 2'b00);
      if (!e.err) mem[a >> 2] = merge(model_rd(a), d, s);
    end
    fork
      begin repeat (daw) @(negedge iCLK); send_aw(a); end
      begin repeat (dw) @(negedge iCLK); send_w(d, s); end
    join
  endtask

  task automatic do_read(input logic [31:0] a);
    be_t   e;
    rexp_t x;
    if (!in_win(a)) begin
      x.data = '0; x.resp = 2'b11;
    end else begin
      e.addr = a; e.data = '0; e.strb = '0; e.err = be_err(a);
      e.lat  = (rd_lat_force >= 0) ? rd_lat_force : int'($urandom_range(0, 4));
      rd_be_q.push_back(e);
      x.resp = e.err ? 2'b10 : 2'b00;
      x.data = e.err ? err_word(a) : model_rd(a);
    end
    r_exp_q.push_back(x);
    send_ar(a);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && n < 300) begin @(negedge iCLK); n++; end
    if (n >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d B and %0d R responses outstanding, required 0", b_exp_q.size(), r_exp_q.size());
    end
    @(negedge iCLK);
  endtask

  initial begin
    int          op, n;
    logic [31:0] wa, ra;
    be_t         e;
    s_AWVALID = 0; s_AWADDR = '0; s_WVALID = 0; s_WDATA = '0; s_WSTRB = '0;
    s_ARVALID = 0; s_ARADDR = '0; s_BREADY = 0; s_RREADY = 0;
    wr_ack = 0; wr_err = 0; rd_ack = 0; rd_err = 0; rd_data = '0;
    #1;
    check("reset_outputs_zero", any_out, 1'b0);
    repeat (3) @(negedge iCLK);
    iRST = 1;
    @(negedge iCLK);
    check("ready_after_reset", {s_AWREADY, s_WREADY, s_ARREADY}, 3'b111);

    // W leads AW by three cycles
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 3, 0);
    wait_idle();

    // Read with slow backend and a stalled R channel
    do_write(32'h20, 32'h12345678, 4'hF, 0, 0);
    wait_idle();
    rd_lat_force = 4; rready_block = 3;
    do_read(32'h20);
    wait_idle();
    rd_lat_force = -1;
    check("rready_stall_seen", rready_block, 0);

    // Write and read issued together
    saw_both = 0;
    fork
      do_write(32'h04, 32'hA5A5_0001, 4'hF, 0, 0);
      do_read(32'h08);
    join
    wait_idle();
    check("wr_rd_req_overlap", saw_both, 1'b1);

    // Backend error and out-of-window accesses
    do_write(32'h900, 32'h0BAD_F00D, 4'hF, 1, 0);
    wait_idle();
    do_read(32'h2000);
    wait_idle();
    do_write(32'h2004, 32'h1111_2222, 4'h3, 0, 2);
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      wa = ($urandom_range(0, 3) == 0) ? ($urandom_range(32'h1F8, 32'h47F) << 2) : ($urandom_range(0, 15) << 2);
      ra = ($urandom_range(0, 3) == 0) ? ($urandom_range(32'h1F8, 32'h47F) << 2) : ($urandom_range(0, 15) << 2);
      while (op == 2 && ra == wa) ra = $urandom_range(0, 15) << 2;
      case (op)
        0: do_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_read(ra);
        default: fork
          do_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
          do_read(ra);
        join
      endcase
      wait_idle();
    end

    // Reset while a read is waiting on the backend
    e.addr = 32'h30; e.data = '0; e.strb = '0; e.err = 0; e.lat = 500;
    rd_be_q.push_back(e);
    send_ar(32'h30);
    n = 0;
    while (!rd_req && n < 20) begin @(negedge iCLK); n++; end
    check("rd_req_before_reset", rd_req, 1'b1);
    #2 iRST = 0;
    #1;
    check("rd_req_async_clear", rd_req, 1'b0);
    check("outputs_async_clear", any_out, 1'b0);
    repeat (2) @(negedge iCLK);
    iRST = 1;
    rd_be_q.delete();
    @(negedge iCLK);
    do_read(32'h20);
    wait_idle();
    do_write(32'h24, 32'hCAFE_0024, 4'hF, 0, 1);
    wait_idle();
    do_read(32'h24);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/axi4_lite_slave_dual.md
AXI4_LITE_SLAVE_DUAL -- requirements
Module: axi4_lite_slave_dual

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI and backend address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (32 or 64); strobe width DATA_WIDTH/8.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first byte address of the decoded window.
REQ-004 SHALL have parameter ADDR_SPAN, default 4096, window size in bytes.
REQ-005 SHALL have iCLK  input  1  clock, all logic on rising edge.
REQ-006 SHALL have iRST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have s_AWVALID  input  1  write address valid.
REQ-008 SHALL have s_AWADDR  input  ADDR_WIDTH  write address.
REQ-009 SHALL have s_AWREADY  output  1  write address ready.
REQ-010 SHALL have s_WVALID  input  1  write data valid.
REQ-011 SHALL have s_WDATA  input  DATA_WIDTH  write data.
REQ-012 SHALL have s_WSTRB  input  DATA_WIDTH/8  byte strobes.
REQ-013 SHALL have s_WREADY  output  1  write data ready.
REQ-014 SHALL have s_BVALID  output  1  write response valid.
REQ-015 SHALL have s_BRESP  output  2  write response code.
REQ-016 SHALL have s_BREADY  input  1  write response ready.
REQ-017 SHALL have s_ARVALID  input  1  read address valid.
REQ-018 SHALL have s_ARADDR  input  ADDR_WIDTH  read address.
REQ-019 SHALL have s_ARREADY  output  1  read address ready.
REQ-020 SHALL have s_RVALID  output  1  read data valid.
REQ-021 SHALL have s_RDATA  output  DATA_WIDTH  read data.
REQ-022 SHALL have s_RRESP  output  2  read response code.
REQ-023 SHALL have s_RREADY  input  1  read data ready.
REQ-024 SHALL have wr_req  output  1  backend write request, held until wr_ack.
REQ-025 SHALL have wr_addr  output  ADDR_WIDTH  registered write address.
REQ-026 SHALL have wr_data  output  DATA_WIDTH  registered write data.
REQ-027 SHALL have wr_strb  output  DATA_WIDTH/8  registered strobes.
REQ-028 SHALL have wr_ack  input  1  backend write complete.
REQ-029 SHALL have wr_err  input  1  backend write error, sampled with wr_ack.
REQ-030 SHALL have rd_req  output  1  backend read request, held until rd_ack.
REQ-031 SHALL have rd_addr  output  ADDR_WIDTH  registered read address.
REQ-032 SHALL have rd_ack  input  1  backend read data valid.
REQ-033 SHALL have rd_data  input  DATA_WIDTH  backend read data, sampled with rd_ack.
REQ-034 SHALL have rd_err  input  1  backend read error, sampled with rd_ack.

Function
REQ-035 Write and read paths SHALL be independent FSMs running concurrently: write W_IDLE->W_BACK->W_RESP->W_IDLE; read R_IDLE->R_BACK->R_DATA->R_IDLE.
REQ-036 In W_IDLE, AW and W SHALL be captured independently in any order or the same cycle: s_AWREADY=1 while AW holding register empty, s_WREADY=1 while W holding register empty; the other channel may be accepted in a later cycle.
REQ-037 W_IDLE->W_BACK SHALL occur on the clock edge at which both AW and W are held; W_BACK drives wr_req=1 with stable wr_addr/wr_data/wr_strb; on wr_ack go to W_RESP, s_BVALID=1, s_BRESP=wr_err?2'b10:2'b00, held stable until s_BREADY, then W_IDLE with holding registers cleared.
REQ-038 In R_IDLE s_ARREADY=1; on handshake capture address, go R_BACK with rd_req=1; on rd_ack register rd_data/rd_err, go R_DATA with s_RVALID=1, s_RRESP=rd_err?2'b10:2'b00; s_RDATA/s_RRESP stable until s_RREADY, then R_IDLE.
REQ-039 Latency with same-cycle ack: first backend request 1 cycle after the last of AW/W/AR handshakes, VALID 1 cycle after ack; all outputs registered, no combinational input-to-output path.
REQ-040 wr_ack/rd_ack outside W_BACK/R_BACK SHALL be ignored; wr_req and rd_req may be asserted in the same cycle, backend arbitrates.
REQ-041 s_RDATA SHALL be 0 whenever s_RVALID=0; s_BRESP/s_RRESP 2'b00 when not valid.

Reset
REQ-042 iRST low SHALL immediately force both FSMs idle, clear holding registers, and drive all outputs 0; an in-flight transaction is dropped with no response.

Configuration
REQ-043 With AXI_LITE_DECERR_EN defined, an address outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN) SHALL skip the backend (no wr_req/rd_req) and go directly to W_RESP/R_DATA with response 2'b11 and s_RDATA=0; without it, no decoding is performed, every address is forwarded, and ADDR_SPAN is unused.

Verification
REQ-044 W before AW: WDATA=0xDEADBEEF, WSTRB=0xF at cycle 0, AW 0x10 at cycle 3 -> one wr_req with wr_addr=0x10, wr_data=0xDEADBEEF; BRESP=00.
REQ-045 Read 0x20, rd_ack 4 cycles after rd_req with rd_data=0x12345678, RREADY low 3 cycles -> RVALID held, RDATA=0x12345678 stable throughout.
REQ-046 Concurrent write 0x04 and read 0x08 same cycle -> wr_req and rd_req both asserted, both responses complete independently.
REQ-047 wr_err=1 with wr_ack -> BRESP=2'b10; with AXI_LITE_DECERR_EN, read 0x2000 (span 4096) -> RRESP=2'b11, RDATA=0, no rd_req.
REQ-048 iRST low during R_BACK -> rd_req and all outputs 0 asynchronously; after release, new read completes normally.
